// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 16-bit pipelined MIPS front end.
//   ADDR_W / INSN_W    : default address and instruction widths
//   pc_t / insn_t      : word types for program counters and instructions
//   NOP_INSN           : bubble encoding placed into pipeline registers
//   HALT_INSN          : encoding that stops instruction fetch
//   RESET_PC           : default program counter after reset
//   fetch_state_t      : fetch FSM states (RUN, HALT)
//   pc_inc()           : wrapping word increment of a program counter
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam int ADDR_W = 16;
    localparam int INSN_W = 16;

    typedef logic [ADDR_W-1:0] pc_t;
    typedef logic [INSN_W-1:0] insn_t;

    localparam insn_t NOP_INSN  = 16'h0000;
    localparam insn_t HALT_INSN = 16'hFFFF;
    localparam pc_t   RESET_PC  = 16'h0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Word-addressed increment; rolls over from all-ones to zero silently.
    function automatic pc_t pc_inc(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// Pipeline register between fetch and decode, with a load enable and a
// synchronous flush that turns the slot into a bubble.
//   clk, rst_n        : clock, asynchronous active-low reset
//   load_en           : capture the *_in values this edge (low = hold)
//   flush             : force a bubble this edge; wins over load_en
//   ins_in            : instruction to capture
//   pc_plus1_in       : PC+1 belonging to ins_in
//   valid_in          : ins_in is a real instruction
//   ins_out           : registered instruction
//   pc_plus1_out      : registered PC+1
//   valid_out         : registered valid flag
// ----------------------------------------------------------------------------
module if_id_reg #(
    parameter int                 ADDR_W   = 16,
    parameter int                 INSN_W   = 16,
    parameter logic [INSN_W-1:0]  NOP_INSN = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              flush,
    input  logic [INSN_W-1:0] ins_in,
    input  logic [ADDR_W-1:0] pc_plus1_in,
    input  logic              valid_in,
    output logic [INSN_W-1:0] ins_out,
    output logic [ADDR_W-1:0] pc_plus1_out,
    output logic              valid_out
);

    logic [INSN_W-1:0] ins_q,      ins_d;
    logic [ADDR_W-1:0] pc_plus1_q, pc_plus1_d;
    logic              valid_q,    valid_d;

    // A flush keeps the old PC+1: nothing downstream looks at it while the
    // slot is a bubble, so there is no reason to clear it.
    always_comb begin
        ins_d      = ins_q;
        pc_plus1_d = pc_plus1_q;
        valid_d    = valid_q;
        if (flush) begin
            ins_d   = NOP_INSN;
            valid_d = 1'b0;
        end else if (load_en) begin
            ins_d      = ins_in;
            pc_plus1_d = pc_plus1_in;
            valid_d    = valid_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_q      <= NOP_INSN;
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            ins_q      <= ins_d;
            pc_plus1_q <= pc_plus1_d;
            valid_q    <= valid_d;
        end
    end

    assign ins_out      = ins_q;
    assign pc_plus1_out = pc_plus1_q;
    assign valid_out    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, addresses a synchronous-read
// instruction memory (data one cycle after the address) and feeds the IF/ID
// register. Handles stalls, branch/jump redirects with flush, and halting.
//   clk, rst_n        : clock, asynchronous active-low reset
//   stall             : hold PC and IF/ID this cycle
//   redirect          : taken branch/jump, kills younger fetches
//   redirect_pc       : redirect target
//   imem_addr         : address to instruction memory
//   imem_ins          : memory data for the address of the previous cycle
//   if_id_ins         : instruction to decode
//   if_id_pc_plus1    : PC+1 of if_id_ins
//   if_id_valid       : if_id_ins is a real instruction
//   halted            : fetch is stopped on a halt instruction
//   fetch_count       : saturating count of valid instructions delivered
// ----------------------------------------------------------------------------
module fetch_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W    = mips_pkg::ADDR_W,
    parameter int                INSN_W    = mips_pkg::INSN_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = mips_pkg::RESET_PC,
    parameter logic [INSN_W-1:0] HALT_INSN = mips_pkg::HALT_INSN,
    parameter logic [INSN_W-1:0] NOP_INSN  = mips_pkg::NOP_INSN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INSN_W-1:0] imem_ins,
    output logic [INSN_W-1:0] if_id_ins,
    output logic [ADDR_W-1:0] if_id_pc_plus1,
    output logic              if_id_valid,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    localparam logic [ADDR_W-1:0] PC_ONE    = 1;
    localparam logic [15:0]       COUNT_MAX = 16'hFFFF;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] f2_pc_q, f2_pc_d;
    logic              f2_valid_q, f2_valid_d;
    logic [15:0]       fetch_count_q, fetch_count_d;

    logic              if_id_load;
    logic              if_id_flush;
    logic [ADDR_W-1:0] f2_pc_plus1;

    assign f2_pc_plus1 = f2_pc_q + PC_ONE;

    // During a stall the address already in flight is presented again, so
    // the memory keeps returning the same word and no skid buffer is needed.
    // A redirect in the same cycle overrides the replay.
    assign imem_addr = (stall && !redirect) ? f2_pc_q : pc_q;

    // Next-state logic. Priority is redirect, then stall, then the HALT
    // state, then normal sequential fetch. A halt instruction is delivered
    // valid on the same edge that moves the FSM into HALT.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        f2_pc_d       = f2_pc_q;
        f2_valid_d    = f2_valid_q;
        fetch_count_d = fetch_count_q;
        if_id_load    = 1'b0;
        if_id_flush   = 1'b0;

        if (redirect) begin
            pc_d        = redirect_pc;
            f2_valid_d  = 1'b0;
            if_id_flush = 1'b1;
            state_d     = RUN;
        end else if (stall) begin
            // everything holds
        end else if (state_q == HALT) begin
            f2_valid_d  = 1'b0;
            if_id_flush = 1'b1;
        end else begin
            if_id_load = 1'b1;
            f2_pc_d    = pc_q;
            f2_valid_d = 1'b1;
            pc_d       = pc_q + PC_ONE;
            if (f2_valid_q) begin
                if (fetch_count_q != COUNT_MAX) begin
                    fetch_count_d = fetch_count_q + 16'd1;
                end
                if (imem_ins == HALT_INSN) begin
                    state_d = HALT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            f2_pc_q       <= '0;
            f2_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            f2_pc_q       <= f2_pc_d;
            f2_valid_q    <= f2_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    if_id_reg #(
        .ADDR_W   (ADDR_W),
        .INSN_W   (INSN_W),
        .NOP_INSN (NOP_INSN)
    ) u_if_id (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_en      (if_id_load),
        .flush        (if_id_flush),
        .ins_in       (imem_ins),
        .pc_plus1_in  (f2_pc_plus1),
        .valid_in     (f2_valid_q),
        .ins_out      (if_id_ins),
        .pc_plus1_out (if_id_pc_plus1),
        .valid_out    (if_id_valid)
    );

    assign halted      = (state_q == HALT);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
// Bench for fetch_stage. A reference model describes the fetch stream as a
// queue of issued addresses and delivers one instruction per unstalled
// cycle. A second instance starts from 16'hFFFE to exercise PC wrap.
// ----------------------------------------------------------------------------
module tb_fetch_stage;
    import mips_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    pc_t         redirectPc;
    pc_t         imemAddr;
    insn_t       imemIns;
    insn_t       ifIdIns;
    pc_t         ifIdPcPlus1;
    logic        ifIdValid;
    logic        halted;
    logic [15:0] fetchCount;

    pc_t         imemAddr2;
    insn_t       imemIns2;
    insn_t       ifIdIns2;
    pc_t         ifIdPcPlus12;
    logic        ifIdValid2;
    logic        halted2;
    logic [15:0] fetchCount2;

    insn_t mem [0:65535];

    int checks = 0;
    int errors = 0;

    // reference model state
    pc_t         mNext;
    pc_t         mLastIssued;
    pc_t         mInflight[$];
    logic        mHalted;
    logic        mValid;
    insn_t       mIns;
    logic        mInsKnown;
    pc_t         mPcPlus1;
    logic [15:0] mCount;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirectPc),
        .imem_addr      (imemAddr),
        .imem_ins       (imemIns),
        .if_id_ins      (ifIdIns),
        .if_id_pc_plus1 (ifIdPcPlus1),
        .if_id_valid    (ifIdValid),
        .halted         (halted),
        .fetch_count    (fetchCount)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (1'b0),
        .redirect       (1'b0),
        .redirect_pc    (16'h0000),
        .imem_addr      (imemAddr2),
        .imem_ins       (imemIns2),
        .if_id_ins      (ifIdIns2),
        .if_id_pc_plus1 (ifIdPcPlus12),
        .if_id_valid    (ifIdValid2),
        .halted         (halted2),
        .fetch_count    (fetchCount2)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memories for both instances
    initial begin
        imemIns  = '0;
        imemIns2 = '0;
    end
    always @(posedge clk) begin
        imemIns  <= mem[imemAddr];
        imemIns2 <= mem[imemAddr2];
    end

    // Single comparison point; every check in the bench goes through here
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mNext       = 16'h0000;
        mLastIssued = 16'h0000;
        mInflight.delete();
        mHalted     = 1'b0;
        mValid      = 1'b0;
        mIns        = NOP_INSN;
        mInsKnown   = 1'b1;
        mPcPlus1    = 16'h0000;
        mCount      = 16'h0000;
    endtask

    // One rising edge of the fetch stream as seen from outside
    task automatic modelEdge(input logic s, input logic r, input pc_t t);
        pc_t a;
        if (r) begin
            mInflight.delete();
            mNext     = t;
            mValid    = 1'b0;
            mIns      = NOP_INSN;
            mInsKnown = 1'b1;
            mHalted   = 1'b0;
        end else if (s) begin
            // frozen
        end else if (mHalted) begin
            mInflight.delete();
            mValid    = 1'b0;
            mIns      = NOP_INSN;
            mInsKnown = 1'b1;
        end else begin
            if (mInflight.size() > 0) begin
                a         = mInflight.pop_front();
                mValid    = 1'b1;
                mIns      = mem[a];
                mInsKnown = 1'b1;
                mPcPlus1  = a + 16'd1;
                if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
                if (mem[a] == HALT_INSN) mHalted = 1'b1;
            end else begin
                mValid    = 1'b0;
                mInsKnown = 1'b0;
            end
            mInflight.push_back(mNext);
            mLastIssued = mNext;
            mNext       = mNext + 16'd1;
        end
    endtask

    task automatic checkState(input string where);
        checkOutput({where, ".valid"},  {31'd0, ifIdValid}, {31'd0, mValid});
        checkOutput({where, ".halted"}, {31'd0, halted},    {31'd0, mHalted});
        checkOutput({where, ".count"},  {16'd0, fetchCount}, {16'd0, mCount});
        if (mInsKnown) checkOutput({where, ".ins"}, {16'd0, ifIdIns}, {16'd0, mIns});
        if (mValid)    checkOutput({where, ".pc_plus1"}, {16'd0, ifIdPcPlus1}, {16'd0, mPcPlus1});
    endtask

    // Called at a falling edge: drive inputs, check the address, clock once
    task automatic applyStimulus(input logic s, input logic r, input pc_t t);
        pc_t expAddr;
        stall      = s;
        redirect   = r;
        redirectPc = t;
        #1;
        expAddr = (s && !r) ? mLastIssued : mNext;
        checkOutput("imem_addr", {16'd0, imemAddr}, {16'd0, expAddr});
        @(posedge clk);
        modelEdge(s, r, t);
        @(negedge clk);
        checkState("if_id");
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = insn_t'($urandom_range(0, 16'hFFFE));
        mem[16'h0000] = 16'h1111;
        mem[16'h0001] = 16'h2222;
        mem[16'h0002] = 16'h3333;
        mem[16'h0003] = 16'h4444;
        mem[16'h0004] = 16'h5555;
        mem[16'h0005] = 16'hFFFF;
        mem[16'h0010] = 16'h1010;
        mem[16'h0020] = 16'h2020;
        mem[16'h0040] = 16'hABCD;
        mem[16'h0041] = 16'hBCDE;
        mem[16'hFFFE] = 16'h1234;
        mem[16'hFFFF] = 16'h5678;

        stall      = 1'b0;
        redirect   = 1'b0;
        redirectPc = 16'h0000;
        rst_n      = 1'b0;
        modelReset();
        $display("[TB] reset asserted");

        repeat (2) @(negedge clk);
        checkOutput("reset.imem_addr", {16'd0, imemAddr}, 32'h0000);
        checkOutput("reset.imem_addr2", {16'd0, imemAddr2}, 32'hFFFE);
        checkState("reset");
        rst_n = 1'b1;

        // Sequential fetch from 0, wrap fetch on the second instance
        applyStimulus(1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("wrap.ins0", {16'd0, ifIdIns2}, 32'h1234);
        checkOutput("wrap.pc1_0", {16'd0, ifIdPcPlus12}, 32'hFFFF);
        checkOutput("wrap.valid0", {31'd0, ifIdValid2}, 32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("wrap.ins1", {16'd0, ifIdIns2}, 32'h5678);
        checkOutput("wrap.pc1_1", {16'd0, ifIdPcPlus12}, 32'h0000);
        checkOutput("wrap.halted", {31'd0, halted2}, 32'd0);

        // Stall while IF/ID holds 2222
        repeat (3) applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("wrap.ins2", {16'd0, ifIdIns2}, {16'd0, mem[16'h0002]});
        checkOutput("wrap.pc1_2", {16'd0, ifIdPcPlus12}, 32'h0003);
        repeat (2) applyStimulus(1'b0, 1'b0, 16'h0000);

        // Redirect to 0x40
        applyStimulus(1'b0, 1'b1, 16'h0040);
        repeat (4) applyStimulus(1'b0, 1'b0, 16'h0000);

        // Stall and redirect together
        applyStimulus(1'b1, 1'b1, 16'h0020);
        repeat (4) applyStimulus(1'b0, 1'b0, 16'h0000);

        // Run into the halt at address 5, then resume at 0x10
        applyStimulus(1'b0, 1'b1, 16'h0003);
        repeat (8) applyStimulus(1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0010);
        repeat (4) applyStimulus(1'b0, 1'b0, 16'h0000);

        // Asynchronous reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        $display("[TB] mid-run reset");
        checkOutput("async.valid",  {31'd0, ifIdValid},  32'd0);
        checkOutput("async.count",  {16'd0, fetchCount}, 32'd0);
        checkOutput("async.ins",    {16'd0, ifIdIns},    32'h0000);
        checkOutput("async.valid2", {31'd0, ifIdValid2}, 32'd0);
        checkOutput("async.count2", {16'd0, fetchCount2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) applyStimulus(1'b0, 1'b0, 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0,
                          pc_t'($urandom_range(0, 150)));
        end

        stall    = 1'b0;
        redirect = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
